ysyx_22050133_div_ctrl: RTL and testbench
=========================================

YSYX_22050133_DIV_CTRL -- requirements
Module: ysyx_22050133_div_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64: operand and result width; only 64 is supported.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port flush, input, 1: cancels any in-flight operation.
REQ-005 SHALL have port in_valid, input, 1: EX-stage divide request valid.
REQ-006 SHALL have port in_ready, output, 1: controller idle, request accepted when in_valid&in_ready.
REQ-007 SHALL have port op, input, 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-008 SHALL have port word, input, 1: W-variant (32-bit operands, sign-extended 32-bit result).
REQ-009 SHALL have ports src1 and src2, input, 64 each: dividend and divisor.
REQ-010 SHALL have port out_valid, output, 1: result valid to writeback.
REQ-011 SHALL have port out_ready, input, 1: writeback accepts result when out_valid&out_ready.
REQ-012 SHALL have port result, output, 64: final quotient or remainder.
REQ-013 SHALL have divider-side outputs div_valid (1), div_flush (1), div_divw (1), div_signed (1), div_dividend (64), div_divisor (64).
REQ-014 SHALL have divider-side inputs div_ready (1), div_out_valid (1), div_quotient (64), div_remainder (64).

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-016 SHALL drive in_ready = (state==IDLE) & ~rst.
REQ-017 SHALL, on accept, latch op, word, src1, src2 into internal registers; divider-side outputs are driven only from these registers.
REQ-018 SHALL, on accept, detect special cases on the effective operands (low 32 bits when word=1): divisor zero, or signed op with dividend = most-negative and divisor = -1.
REQ-019 SHALL, for divisor zero, produce quotient all-ones and remainder equal to the effective dividend; go IDLE->DONE with out_valid high the cycle after accept; never assert div_valid.
REQ-020 SHALL, for signed overflow, produce quotient equal to the effective dividend and remainder 0; go IDLE->DONE identically.
REQ-021 SHALL otherwise go IDLE->ISSUE and hold div_valid=1 with stable operands until a cycle where div_ready=1, then go ISSUE->WAIT.
REQ-022 SHALL, in WAIT only, treat div_out_valid=1 as completion; div_out_valid in any other state, including the ISSUE handshake cycle, SHALL be ignored.
REQ-023 SHALL, on completion, register the quotient (op 0x) or remainder (op 1x) and go WAIT->DONE.
REQ-024 SHALL, when word=1, set result = sign-extension of bit 31 of the selected 32-bit value, for both signed and unsigned ops.
REQ-025 SHALL drive div_signed = ~op[0] and div_divw = word.
REQ-026 SHALL hold out_valid=1 and result stable in DONE until out_ready=1, then return to IDLE the next cycle.
REQ-027 SHALL, on flush in any state, go to IDLE the next cycle, deassert out_valid and div_valid, and discard pending results.
REQ-028 SHALL pulse div_flush for exactly one cycle when flush is seen in ISSUE or WAIT.
REQ-029 SHALL give flush priority over a simultaneous in_valid, div_ready, div_out_valid, or out_ready.
REQ-030 SHALL, after a flush, issue the next request only once div_ready=1.

Reset
REQ-031 SHALL, while rst=1, force state IDLE and drive in_ready=0, out_valid=0, result=0, div_valid=0, div_flush=0.
REQ-032 SHALL, when rst asserts mid-operation, abandon the operation without div_flush; the next request waits for div_ready.

Verification
REQ-033 DIV src1=0xFFFF_FFFF_FFFF_FFF9, src2=2 -> result 0xFFFF_FFFF_FFFF_FFFD; REM with the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-034 DIVU src1=5, src2=0 -> div_valid stays 0; out_valid the cycle after accept; result 0xFFFF_FFFF_FFFF_FFFF; REMU -> 5.
REQ-035 DIVW src1=0x8000_0000, src2=0xFFFF_FFFF -> no divider request; result 0xFFFF_FFFF_8000_0000; REMW -> 0.
REQ-036 DIVUW src1=0xFFFF_FFFF, src2=1 -> 0xFFFF_FFFF_FFFF_FFFF; REMUW src1=0x1_0000_0007, src2=3 -> 1.
REQ-037 Hold out_ready=0 for 3 cycles in DONE -> out_valid and result unchanged and in_ready=0 throughout; in_ready=1 the cycle after out_ready=1.
REQ-038 Assert flush in WAIT -> div_flush for one cycle, in_ready=1 the next cycle, no out_valid; a following DIVU 100/7 -> 14.

Source files
------------

// File: rtl/ysyx_22050133_div_ctrl.sv
// Divide/remainder controller between the EX stage and an iterative divider.
// Accepts one request at a time, resolves divide-by-zero and signed overflow
// locally, otherwise hands registered operands to the divider and forwards the
// selected quotient/remainder to writeback (sign-extended for W variants).
module ysyx_22050133_div_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    // EX-stage request
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    // writeback response
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    // divider side
    output logic            div_valid,
    output logic            div_flush,
    output logic            div_divw,
    output logic            div_signed,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    input  logic            div_ready,
    input  logic            div_out_valid,
    input  logic [XLEN-1:0] div_quotient,
    input  logic [XLEN-1:0] div_remainder
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q, state_d;
    logic [1:0]      op_q;
    logic            word_q;
    logic [XLEN-1:0] src1_q;
    logic [XLEN-1:0] src2_q;
    logic [XLEN-1:0] result_q, result_d;

    logic            accept;
    logic            divisor_zero;
    logic            signed_ovf;
    logic            special;
    logic [XLEN-1:0] special_sel;
    logic [XLEN-1:0] done_sel;

    // W variants always return bit 31 replicated into the upper half,
    // regardless of whether the operation itself was signed.
    function automatic logic [XLEN-1:0] fmt_result(input logic w, input logic [XLEN-1:0] v);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    // Flush wins over a simultaneous request, so nothing is latched that cycle.
    assign in_ready = (state_q == S_IDLE) && !rst;
    assign accept   = in_valid && in_ready && !flush;

    // Special-case detection on the effective (possibly 32-bit) operands.
    always_comb begin
        divisor_zero = word ? (src2[31:0] == 32'd0) : (src2 == '0);
        signed_ovf   = !op[0] && (word ? ((src1[31:0] == 32'h8000_0000) && (src2[31:0] == 32'hFFFF_FFFF))
                                       : ((src1 == MOST_NEG) && (src2 == '1)));
        special      = divisor_zero || signed_ovf;
        if (divisor_zero) begin
            special_sel = op[1] ? src1 : '1;
        end else begin
            special_sel = op[1] ? '0 : src1;
        end
        done_sel = op_q[1] ? div_remainder : div_quotient;
    end

    // Next-state and result-capture logic; flush overrides every other event.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (special) begin
                        state_d  = S_DONE;
                        result_d = fmt_result(word, special_sel);
                    end else begin
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // div_out_valid is deliberately not looked at here.
                if (div_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (div_out_valid) begin
                    state_d  = S_DONE;
                    result_d = fmt_result(word_q, done_sel);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // State, result and latched request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            op_q     <= 2'b00;
            word_q   <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            if (accept) begin
                op_q   <= op;
                word_q <= word;
                src1_q <= src1;
                src2_q <= src2;
            end
        end
    end

    // Divider request is withdrawn in a flush cycle so no handshake races the cancel.
    assign div_valid    = (state_q == S_ISSUE) && !flush && !rst;
    assign div_flush    = flush && ((state_q == S_ISSUE) || (state_q == S_WAIT)) && !rst;
    assign div_divw     = word_q;
    assign div_signed   = !op_q[0];
    assign div_dividend = src1_q;
    assign div_divisor  = src2_q;

    assign out_valid    = (state_q == S_DONE) && !rst;
    assign result       = rst ? '0 : result_q;

endmodule

// File: tb/tb_ysyx_22050133_div_ctrl.sv
// Bench for the divide controller: a behavioural divider stub answers the
// divider-side handshake, directed vectors push expected results into a
// queue, and a monitor pops and compares on every writeback handshake.
module tb_ysyx_22050133_div_ctrl;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, word, out_valid, out_ready;
    logic [1:0]  op;
    logic [63:0] src1, src2, result;
    logic        div_valid, div_flush, div_divw, div_signed, div_ready;
    logic [63:0] div_dividend, div_divisor;
    logic        div_out_valid = 1'b0;
    logic [63:0] div_quotient  = '0;
    logic [63:0] div_remainder = '0;

    always #5 clk = ~clk;

    ysyx_22050133_div_ctrl #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .word(word),
        .src1(src1), .src2(src2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .div_valid(div_valid), .div_flush(div_flush), .div_divw(div_divw),
        .div_signed(div_signed), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_ready(div_ready), .div_out_valid(div_out_valid),
        .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int out_idx   = 0;
    logic [63:0] exp_q[$];
    bit div_valid_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // ---------------- divider stub ----------------
    bit          ready_en = 1;
    bit          inject   = 0;
    int          lat      = 3;
    bit          m_busy   = 0;
    int          m_cnt    = 0;
    logic [63:0] m_a = '0, m_b = '0;
    logic        m_sgn = 1'b0, m_w = 1'b0;

    assign div_ready = ready_en && !m_busy;

    function automatic void model_div(input logic [63:0] a, input logic [63:0] b,
                                      input logic sgn, input logic w,
                                      output logic [63:0] q, output logic [63:0] r);
        logic [31:0] a32, b32, q32, r32;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 32'd0) begin q32 = '1; r32 = a32; end
            else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = '0; end
            else if (sgn) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
            else begin q32 = a32 / b32; r32 = a32 % b32; end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) begin q = '1; r = a; end
            else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = '0; end
            else if (sgn) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
            else begin q = a / b; r = a % b; end
        end
    endfunction

    // Divider stub: fixed latency, cleared by div_flush, optional spurious done pulses.
    always @(posedge clk) begin
        logic [63:0] q, r;
        div_out_valid <= 1'b0;
        if (div_flush) begin
            m_busy <= 0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                model_div(m_a, m_b, m_sgn, m_w, q, r);
                m_busy        <= 0;
                div_out_valid <= 1'b1;
                div_quotient  <= q;
                div_remainder <= r;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (div_valid && div_ready) begin
            m_busy <= 1;
            m_cnt  <= lat;
            m_a    <= div_dividend;
            m_b    <= div_divisor;
            m_sgn  <= div_signed;
            m_w    <= div_divw;
        end
        if (inject) begin
            div_out_valid <= 1'b1;
            div_quotient  <= 64'hDEAD_BEEF_DEAD_BEEF;
            div_remainder <= 64'hBAD0_BAD0_BAD0_BAD0;
        end
    end

    // ---------------- monitor ----------------
    // Compare every writeback handshake against the oldest expected result.
    always @(negedge clk) begin
        if (div_valid) div_valid_seen = 1;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check($sformatf("unexpected_out_%0d", out_idx), result, 64'hx);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check($sformatf("out_%0d", out_idx), result, e);
            end
            $display("out %0d: result=%h", out_idx, result);
            out_idx++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [1:0] o, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp,
                         input bit special, input bit push);
        bit acc;
        acc = 0;
        @(posedge clk); #1;
        in_valid = 1; op = o; word = w; src1 = a; src2 = b;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc && push) exp_q.push_back(exp);
            if (!acc) @(posedge clk);
        end
        @(posedge clk); #1;
        in_valid = 0;
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
        $display("req op=%0d w=%0d a=%h b=%h exp=%h", o, w, a, b, exp);
        if (special) begin
            @(negedge clk);
            check("special_out_valid_next", {63'd0, out_valid}, 64'd1);
            check("special_no_div_valid", {63'd0, div_valid}, 64'd0);
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && in_ready;
        end
        if (!ok) check("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_busy();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = m_busy;
        end
        if (!ok) check("divider_accept_timeout", 64'd0, 64'd1);
    endtask

    typedef struct packed {
        logic [1:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        logic        special;
    } vec_t;
    vec_t vecs[$];

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; flush = 0; in_valid = 1; op = 2'b00; word = 0;
        src1 = 64'd9; src2 = 64'd3; out_ready = 1;

        // Reset state with a request pending at the input.
        repeat (3) @(negedge clk);
        check("rst_in_ready",  {63'd0, in_ready},  64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result",    result,             64'd0);
        check("rst_div_valid", {63'd0, div_valid}, 64'd0);
        check("rst_div_flush", {63'd0, div_flush}, 64'd0);
        @(posedge clk); #1;
        rst = 0; in_valid = 0;

        // Directed vectors: op, word, src1, src2, expected result, special-case.
        vecs.push_back({2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0});
        vecs.push_back({2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
        vecs.push_back({2'd1, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1});
        vecs.push_back({2'd3, 1'b0, 64'd5, 64'd0, 64'd5, 1'b1});
        vecs.push_back({2'd0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1});
        vecs.push_back({2'd2, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1'b1});
        vecs.push_back({2'd1, 1'b1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
        vecs.push_back({2'd3, 1'b1, 64'h1_0000_0007, 64'd3, 64'd1, 1'b0});
        vecs.push_back({2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1});
        vecs.push_back({2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1});
        vecs.push_back({2'd0, 1'b1, 64'h1234_5678_8000_0001, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1});
        vecs.push_back({2'd2, 1'b1, 64'h1234_5678_8000_0001, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0001, 1'b1});
        vecs.push_back({2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0});
        vecs.push_back({2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 1'b0});
        vecs.push_back({2'd1, 1'b1, 64'h8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 1'b0});
        vecs.push_back({2'd3, 1'b1, 64'hFFFF_FFFF, 64'h10, 64'd15, 1'b0});

        foreach (vecs[i]) begin
            div_valid_seen = 0;
            issue(vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].special, 1);
            drain();
            if (vecs[i].special)
                check($sformatf("special_div_valid_never_%0d", i), {63'd0, div_valid_seen}, 64'd0);
        end

        // Writeback back-pressure: result held for three cycles in DONE.
        begin
            bit ok;
            ok = 0;
            @(posedge clk); #1;
            out_ready = 0;
            lat = 2;
            issue(2'd1, 1'b0, 64'd1000, 64'd10, 64'd100, 0, 1);
            for (int i = 0; i < 100 && !ok; i++) begin
                @(negedge clk);
                ok = out_valid;
            end
            if (!ok) check("hold_out_valid_timeout", 64'd0, 64'd1);
            for (int k = 0; k < 3; k++) begin
                if (k > 0) @(negedge clk);
                check($sformatf("hold_out_valid_%0d", k), {63'd0, out_valid}, 64'd1);
                check($sformatf("hold_result_%0d", k), result, 64'd100);
                check($sformatf("hold_in_ready_%0d", k), {63'd0, in_ready}, 64'd0);
            end
            @(posedge clk); #1;
            out_ready = 1;
            @(negedge clk);
            @(negedge clk);
            check("hold_release_in_ready", {63'd0, in_ready}, 64'd1);
            check("hold_release_out_valid", {63'd0, out_valid}, 64'd0);
        end

        // Flush while waiting on the divider, then a request that must wait for div_ready.
        lat = 8;
        issue(2'd0, 1'b0, 64'd100, 64'd7, 64'd0, 0, 0);
        wait_busy();
        @(posedge clk); #1;
        flush = 1;
        @(negedge clk);
        check("flush_div_flush_pulse", {63'd0, div_flush}, 64'd1);
        @(posedge clk); #1;
        flush = 0;
        ready_en = 0;
        @(negedge clk);
        check("flush_div_flush_drop", {63'd0, div_flush}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        check("flush_no_out_valid", {63'd0, out_valid}, 64'd0);
        lat = 3;
        issue(2'd1, 1'b0, 64'd100, 64'd7, 64'd14, 0, 1);
        inject = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("issue_hold_div_valid_%0d", k), {63'd0, div_valid}, 64'd1);
            check($sformatf("issue_hold_dividend_%0d", k), div_dividend, 64'd100);
            check($sformatf("issue_hold_out_valid_%0d", k), {63'd0, out_valid}, 64'd0);
        end
        @(posedge clk); #1;
        inject = 0;
        ready_en = 1;
        drain();

        // Reset mid-operation: no div_flush, and the next request waits for the divider.
        lat = 6;
        issue(2'd0, 1'b0, 64'd50, 64'd5, 64'd0, 0, 0);
        wait_busy();
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        check("midrst_div_flush", {63'd0, div_flush}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        check("midrst_result", result, 64'd0);
        @(posedge clk); #1;
        rst = 0;
        issue(2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
        drain();

        repeat (5) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
